// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style datapath: widths, the hardwired-zero
// register number and the ALU operation encoding.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SLL = 3'd3,
        ALU_SRA = 3'd4,
        ALU_SRL = 3'd5,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector for one source register: picks the youngest
// in-flight producer (MEM before WB), falling back to the register-file value.
// Register 0 always reads as zero, even if some stage claims to write it.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] regval,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wa,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] val
);

    // Priority select: zero register, then MEM, then WB, then register file.
    always_comb begin
        val = regval;
        if (src == '0) begin
            val = '0;
        end else if (mem_regwrite && (mem_wa == src)) begin
            val = mem_result;
        end else if (wb_regwrite && (wb_wa == src)) begin
            val = wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// The EX register feeds the ALU operand muxes directly, so forwarding costs
// no extra cycle; a load in EX whose result the ID instruction needs forces
// a one-cycle bubble while ID holds.
module ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [2:0]        id_alucont,
    input  logic              id_alusrc,
    input  logic              id_shiftsrc,
    input  logic [REG_AW-1:0] id_wa,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              id_memwrite,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wa,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              hold,
    input  logic              flush,
    output logic              lu_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        ex_alucont,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_wa,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_memwrite
);

    logic              valid_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;
    logic [2:0]        alucont_q;
    logic              alusrc_q;
    logic              shiftsrc_q;
    logic [REG_AW-1:0] wa_q;
    logic              regwrite_q;
    logic              memtoreg_q;
    logic              memwrite_q;

    logic              rs_needed;
    logic              rt_needed;
    logic              load_en;
    logic              bubble;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Load-use hazard: a load in EX writes a register ID reads this cycle.
    // rt only matters when it is an ALU operand or store data.
    always_comb begin
        rs_needed = (wa_q == id_rs);
        rt_needed = (wa_q == id_rt) && (!id_alusrc || id_memwrite);
        lu_stall  = !hold && valid_q && memtoreg_q && regwrite_q &&
                    (wa_q != REG_ZERO) && id_valid && (rs_needed || rt_needed);
    end

    // Flush beats hold; a stall only takes effect when EX is free to advance.
    always_comb begin
        load_en = flush || !hold;
        bubble  = flush || lu_stall;
    end

    // EX pipeline register; a bubble clears every field so stale register
    // numbers cannot trigger forwarding or hazards downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            alucont_q  <= ALU_AND;
            alusrc_q   <= 1'b0;
            shiftsrc_q <= 1'b0;
            wa_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (load_en) begin
            valid_q    <= bubble ? 1'b0 : id_valid;
            rs_q       <= bubble ? '0 : id_rs;
            rt_q       <= bubble ? '0 : id_rt;
            rs_data_q  <= bubble ? '0 : id_rs_data;
            rt_data_q  <= bubble ? '0 : id_rt_data;
            imm_q      <= bubble ? '0 : id_imm;
            shamt_q    <= bubble ? '0 : id_shamt;
            alucont_q  <= bubble ? ALU_AND : id_alucont;
            alusrc_q   <= bubble ? 1'b0 : id_alusrc;
            shiftsrc_q <= bubble ? 1'b0 : id_shiftsrc;
            wa_q       <= bubble ? '0 : id_wa;
            regwrite_q <= bubble ? 1'b0 : (id_regwrite & id_valid);
            memtoreg_q <= bubble ? 1'b0 : (id_memtoreg & id_valid);
            memwrite_q <= bubble ? 1'b0 : (id_memwrite & id_valid);
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src          (rs_q),
        .regval       (rs_data_q),
        .mem_regwrite (mem_regwrite),
        .mem_wa       (mem_wa),
        .mem_result   (mem_result),
        .wb_regwrite  (wb_regwrite),
        .wb_wa        (wb_wa),
        .wb_result    (wb_result),
        .val          (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src          (rt_q),
        .regval       (rt_data_q),
        .mem_regwrite (mem_regwrite),
        .mem_wa       (mem_wa),
        .mem_result   (mem_result),
        .wb_regwrite  (wb_regwrite),
        .wb_wa        (wb_wa),
        .wb_result    (wb_result),
        .val          (fwd_rt)
    );

    // ALU operand source selection and registered control outputs.
    always_comb begin
        alu_a         = shiftsrc_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
        alu_b         = alusrc_q ? imm_q : fwd_rt;
        ex_store_data = fwd_rt;
        ex_valid      = valid_q;
        ex_alucont    = alucont_q;
        ex_wa         = wa_q;
        ex_regwrite   = regwrite_q & valid_q;
        ex_memtoreg   = memtoreg_q & valid_q;
        ex_memwrite   = memwrite_q & valid_q;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios with fixed expectations,
// then a randomized run checked against a slot-level reference model.
module tb_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_wa;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [2:0]  id_alucont;
    logic        id_alusrc, id_shiftsrc;
    logic        id_regwrite, id_memtoreg, id_memwrite;
    logic        mem_regwrite;
    logic [4:0]  mem_wa;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_wa;
    logic [31:0] wb_result;
    logic        hold, flush;
    logic        lu_stall, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  ex_alucont;
    logic [4:0]  ex_wa;
    logic        ex_regwrite, ex_memtoreg, ex_memwrite;

    int n_vec = 0;
    int n_err = 0;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alucont(id_alucont),
        .id_alusrc(id_alusrc), .id_shiftsrc(id_shiftsrc), .id_wa(id_wa),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
        .mem_regwrite(mem_regwrite), .mem_wa(mem_wa), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_wa(wb_wa), .wb_result(wb_result),
        .hold(hold), .flush(flush), .lu_stall(lu_stall), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .ex_alucont(ex_alucont),
        .ex_store_data(ex_store_data), .ex_wa(ex_wa), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_wa = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
        id_alucont = 0; id_alusrc = 0; id_shiftsrc = 0;
        id_regwrite = 0; id_memtoreg = 0; id_memwrite = 0;
        mem_regwrite = 0; mem_wa = 0; mem_result = 0;
        wb_regwrite = 0; wb_wa = 0; wb_result = 0;
        hold = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the instruction currently occupying EX.
    typedef struct packed {
        bit        valid;
        bit [4:0]  rs, rt, wa, shamt;
        bit [31:0] rsd, rtd, imm;
        bit [2:0]  op;
        bit        alusrc, shiftsrc, rw, mtr, mw;
    } ex_slot_t;

    ex_slot_t m;

    // Value an EX source register should read given the in-flight producers.
    function automatic logic [31:0] want_operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return 32'h0;
        if (mem_regwrite && mem_wa == r) return mem_result;
        if (wb_regwrite && wb_wa == r) return wb_result;
        return rf;
    endfunction

    // A load in EX whose destination the ID instruction consumes must delay it.
    function automatic logic want_stall();
        logic uses_rs, uses_rt, ex_is_load;
        ex_is_load = m.valid && m.mtr && m.rw && (m.wa != 0);
        uses_rs    = (id_rs == m.wa);
        uses_rt    = (id_rt == m.wa) && (!id_alusrc || id_memwrite);
        return !hold && ex_is_load && id_valid && (uses_rs || uses_rt);
    endfunction

    logic keep_id;
    logic e_stall;
    logic [31:0] e_rt;

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(ex_valid), 32'h0);
        check_val("rst_alucont", 32'(ex_alucont), 32'h0);
        check_val("rst_wa", 32'(ex_wa), 32'h0);
        check_val("rst_regwrite", 32'(ex_regwrite), 32'h0);
        check_val("rst_alu_a", alu_a, 32'h0);
        check_val("rst_alu_b", alu_b, 32'h0);
        check_val("rst_stall", 32'(lu_stall), 32'h0);
        reset = 1'b0;

        // MEM beats WB; WB used once MEM stops matching.
        id_valid = 1; id_rs = 3; id_rs_data = 32'h99; id_alucont = 3'd2;
        id_regwrite = 1; id_wa = 4;
        tick();
        idle();
        mem_regwrite = 1; mem_wa = 3; mem_result = 32'h11;
        wb_regwrite = 1; wb_wa = 3; wb_result = 32'h22;
        #1;
        check_val("fwd_mem_pri", alu_a, 32'h11);
        check_val("add_alucont", 32'(ex_alucont), 32'h2);
        check_val("add_regwrite", 32'(ex_regwrite), 32'h1);
        mem_regwrite = 0;
        #1;
        check_val("fwd_wb", alu_a, 32'h22);
        wb_regwrite = 0;
        #1;
        check_val("fwd_none", alu_a, 32'h99);

        // Register 0 is never forwarded.
        id_valid = 1; id_rs = 0; id_rs_data = 32'h55;
        tick();
        idle();
        mem_regwrite = 1; mem_wa = 0; mem_result = 32'hFFFF;
        #1;
        check_val("r0_no_fwd", alu_a, 32'h0);
        idle();

        // Shift: a = shamt, b = rt.  Store: b = imm, store data = forwarded rt.
        id_valid = 1; id_shamt = 4; id_shiftsrc = 1; id_rt = 2; id_rt_data = 32'h1;
        id_alucont = 3'd3; id_regwrite = 1; id_wa = 9;
        tick();
        idle();
        #1;
        check_val("sll_a", alu_a, 32'h4);
        check_val("sll_b", alu_b, 32'h1);
        id_valid = 1; id_alusrc = 1; id_imm = 8; id_rt = 6; id_rt_data = 32'h1234;
        id_memwrite = 1; id_alucont = 3'd2; id_rs = 1; id_rs_data = 32'h40;
        tick();
        idle();
        mem_regwrite = 1; mem_wa = 6; mem_result = 32'hABCD;
        #1;
        check_val("sw_b", alu_b, 32'h8);
        check_val("sw_store", ex_store_data, 32'hABCD);
        check_val("sw_memwrite", 32'(ex_memwrite), 32'h1);
        idle();

        // Load-use: lw r5 then add using r5.
        id_valid = 1; id_rs = 1; id_rs_data = 32'h100; id_alusrc = 1; id_imm = 4;
        id_regwrite = 1; id_memtoreg = 1; id_wa = 5; id_alucont = 3'd2;
        tick();
        id_rs = 5; id_rt = 7; id_alusrc = 0; id_memtoreg = 0; id_wa = 8;
        id_rs_data = 32'h555; id_rt_data = 32'h3;
        #1;
        check_val("lu_stall_set", 32'(lu_stall), 32'h1);
        tick();
        check_val("lu_bubble_valid", 32'(ex_valid), 32'h0);
        check_val("lu_bubble_rw", 32'(ex_regwrite), 32'h0);
        check_val("lu_stall_clear", 32'(lu_stall), 32'h0);
        tick();
        id_valid = 0;
        wb_regwrite = 1; wb_wa = 5; wb_result = 32'h777;
        #1;
        check_val("lu_add_valid", 32'(ex_valid), 32'h1);
        check_val("lu_add_a", alu_a, 32'h777);
        check_val("lu_add_b", alu_b, 32'h3);

        // Hold freezes EX; flush wins over hold.
        hold = 1; id_valid = 1; id_rs = 1; id_wa = 12; id_alucont = 3'd6;
        tick();
        tick();
        check_val("hold_wa", 32'(ex_wa), 32'h8);
        check_val("hold_alucont", 32'(ex_alucont), 32'h2);
        check_val("hold_a", alu_a, 32'h777);
        flush = 1;
        tick();
        check_val("flush_valid", 32'(ex_valid), 32'h0);
        check_val("flush_wa", 32'(ex_wa), 32'h0);
        idle();

        // Reset mid-stream clears the in-flight instruction.
        id_valid = 1; id_rs = 2; id_rs_data = 32'h42; id_rt = 3; id_rt_data = 32'h5;
        id_regwrite = 1; id_wa = 9;
        tick();
        check_val("pre_rst_valid", 32'(ex_valid), 32'h1);
        reset = 1;
        #1;
        check_val("mid_rst_valid", 32'(ex_valid), 32'h0);
        check_val("mid_rst_rw", 32'(ex_regwrite), 32'h0);
        check_val("mid_rst_a", alu_a, 32'h0);
        check_val("mid_rst_b", alu_b, 32'h0);
        tick();
        reset = 0;
        tick();
        check_val("post_rst_valid", 32'(ex_valid), 32'h1);
        check_val("post_rst_a", alu_a, 32'h42);
        idle();

        // Randomized run against the slot model.
        @(negedge clk);
        reset = 1;
        m = '0;
        @(negedge clk);
        reset = 0;
        keep_id = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 59) == 0);
            if (!keep_id) begin
                id_valid    = ($urandom_range(0, 5) != 0);
                id_rs       = 5'($urandom_range(0, 3));
                id_rt       = 5'($urandom_range(0, 3));
                id_wa       = 5'($urandom_range(0, 3));
                id_rs_data  = $urandom;
                id_rt_data  = $urandom;
                id_imm      = $urandom;
                id_shamt    = 5'($urandom_range(0, 31));
                id_alucont  = 3'($urandom_range(0, 7));
                id_alusrc   = 1'($urandom_range(0, 1));
                id_shiftsrc = ($urandom_range(0, 3) == 0);
                id_regwrite = 1'($urandom_range(0, 1));
                id_memtoreg = 1'($urandom_range(0, 1));
                id_memwrite = ($urandom_range(0, 3) == 0);
            end
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_wa       = 5'($urandom_range(0, 3));
            mem_result   = $urandom;
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_wa        = 5'($urandom_range(0, 3));
            wb_result    = $urandom;
            hold         = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            if (reset) m = '0;
            #1;
            e_stall = want_stall();
            e_rt    = want_operand(m.rt, m.rtd);
            check_val("r_stall", 32'(lu_stall), 32'(e_stall));
            check_val("r_valid", 32'(ex_valid), 32'(m.valid));
            check_val("r_alu_a", alu_a, m.shiftsrc ? {27'b0, m.shamt} : want_operand(m.rs, m.rsd));
            check_val("r_alu_b", alu_b, m.alusrc ? m.imm : e_rt);
            check_val("r_store", ex_store_data, e_rt);
            check_val("r_alucont", 32'(ex_alucont), 32'(m.op));
            check_val("r_wa", 32'(ex_wa), 32'(m.wa));
            check_val("r_regwrite", 32'(ex_regwrite), 32'(m.rw & m.valid));
            check_val("r_memtoreg", 32'(ex_memtoreg), 32'(m.mtr & m.valid));
            check_val("r_memwrite", 32'(ex_memwrite), 32'(m.mw & m.valid));
            @(posedge clk);
            if (!reset) begin
                if (flush || (!hold && e_stall)) begin
                    m = '0;
                end else if (!hold) begin
                    m.valid = id_valid;
                    m.rs = id_rs; m.rt = id_rt; m.wa = id_wa; m.shamt = id_shamt;
                    m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
                    m.op = id_alucont; m.alusrc = id_alusrc; m.shiftsrc = id_shiftsrc;
                    m.rw = id_regwrite & id_valid;
                    m.mtr = id_memtoreg & id_valid;
                    m.mw = id_memwrite & id_valid;
                end
            end
            keep_id = e_stall && !reset && !flush;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
